mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multicycle CPU's data/instruction memory port: accepts the byte/half/word read and write requests the control FSM issues (MemWrite/MemRead plus funct3-encoded MemOp), services them against an internal word-organised RAM with programmable wait states, and returns lane-extracted, sign/zero-extended read data with a one-cycle Ready pulse. Sub-word stores are performed as read-modify-write inside the block. Sits between the datapath's address/write-data mux and the CPU's ReadData register.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words, power of two.
- LATENCY, 2: wait-state cycles per access, 0..15.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- MemRead  input  1  read request, sampled only when Busy=0.
- MemWrite  input  1  write request, sampled only when Busy=0; wins over MemRead if both high.
- MemOp  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W.
- Addr  input  32  byte address.
- WriteData  input  32  store data, low bits used for B/H.
- ReadData  output  32  extended load data, valid in Ready cycle, held until next completion.
- Ready  output  1  one-cycle completion pulse.
- Busy  output  1  request in flight; new requests ignored.
- Fault  output  1  misalignment flag, valid with Ready (see Configuration).

## Operation
- States: IDLE, WAIT, MERGE, DONE.
- IDLE: on MemRead|MemWrite, capture Addr, WriteData, MemOp, direction; go WAIT (LATENCY>0) else MERGE (sub-word write) else DONE.
- WAIT: counter loaded with LATENCY-1 at acceptance, decrements; at 0 go MERGE (SB/SH) or DONE.
- MERGE: read addressed word, replace byte/half lane selected by Addr[1:0]/Addr[1], go DONE.
- DONE: Ready=1; write (full word or merged word) commits to RAM on the edge entering DONE; go IDLE.
- Busy=1 in WAIT, MERGE, DONE; 0 in IDLE.
- Word index = Addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo DEPTH_WORDS).
- Loads: B/BU pick byte Addr[1:0], H/HU pick half Addr[1]; B/H sign-extend, BU/HU zero-extend; W full word.
- ReadData unchanged on write completions.
- Reset values: state IDLE, Ready 0, Busy 0, Fault 0, ReadData 0, counter 0. RAM contents not reset.
- rst mid-operation: return to IDLE next edge, uncommitted write discarded, no Ready pulse.

## Timing
- Request accepted at edge E0 (state IDLE).
- Loads and word stores: Ready high in cycle LATENCY+1 after E0.
- SB/SH: Ready high in cycle LATENCY+2 after E0 (one MERGE cycle).
- Earliest next acceptance: edge ending the Ready cycle is not an acceptance edge; next request sampled one cycle after Ready.
- Read accepted after a write's Ready sees the written data.
- Inputs need only be valid at E0.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: H/HU/SH with Addr[0]=1, or W/SW with Addr[1:0]≠0, still completes with normal latency but Fault=1 in the Ready cycle, no RAM write, ReadData set to 0.
- Not defined: misaligned low address bits are forced to 0 for the access size (half-aligned or word-aligned); Fault tied to 0.

## Test plan
- LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> Ready 3 cycles after each acceptance, ReadData=0xDEADBEEF.
- SB 0x7F to 0x11 over 0xDEADBEEF, then LB 0x11 / LBU 0x13 -> Ready 4 cycles after SB; word 0xDEAD7FEF; LB=0x0000007F, LBU=0x000000DE.
- LH 0x12 over 0x80001234 then LHU 0x12 -> 0xFFFF8000, then 0x00008000.
- MemRead pulsed while Busy=1 with different Addr -> ignored, ReadData reflects only first request; MemRead+MemWrite together -> write performed.
- SW to 0x20 with rst asserted in WAIT -> no Ready pulse, Busy=0 next cycle, later LW 0x20 returns prior contents.
- MEM_MISALIGN_TRAP_EN: SW to 0x22 -> Ready with Fault=1, word at 0x20 unchanged; without macro -> write lands at 0x20, Fault=0.

Source files
------------

// File: rtl/mem_if.sv
// mem_if: request/response bundle between the CPU control path and the
// memory responder.
//   MemRead, MemWrite : request strobes (master -> slave)
//   MemOp             : funct3 access size / signedness
//   Addr, WriteData   : byte address and store data
//   ReadData          : extended load data (slave -> master)
//   Ready             : one-cycle completion pulse
//   Busy              : access in flight, requests ignored
//   Fault             : misalignment flag, meaningful with Ready
interface mem_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  MemOp;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Busy;
    logic        Fault;

    modport master (
        output MemRead, MemWrite, MemOp, Addr, WriteData,
        input  ReadData, Ready, Busy, Fault
    );

    modport slave (
        input  MemRead, MemWrite, MemOp, Addr, WriteData,
        output ReadData, Ready, Busy, Fault
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind the multicycle CPU memory port.
// Accepts B/H/W (signed and unsigned) loads and stores, inserts LATENCY
// wait states, performs sub-word stores as read-modify-write and returns
// the extended load data together with a one-cycle Ready pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_if.slave (MemRead, MemWrite, MemOp, Addr, WriteData in;
//              ReadData, Ready, Busy, Fault out)
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned H/W
// accesses with Fault (no write, ReadData cleared). Without it the low
// address bits below the access size are ignored and Fault is 0.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic clk,
    input logic rst,
    mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, MERGE, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  op_q;
    logic        wr_q;
    logic [31:0] ram [DEPTH_WORDS];

    logic          accept, finish, flt, subword;
    logic [31:0]   cur_addr, cur_wd, cur_word, new_word;
    logic [2:0]    cur_op;
    logic          cur_wr;
    logic [AW-1:0] cur_idx;
    logic          unused_addr;

    // B/H/W sign or zero extension of the addressed lane.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  op);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        b  = w[{lo, 3'b000} +: 8];
        h  = lo[1] ? w[31:16] : w[15:0];
        sb = b;
        sh = h;
        case (op)
            3'b000:  r = sb;
            3'b001:  r = sh;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the byte or half lane of w with the low bits of wd.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  op,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        if (op[1:0] == 2'b00) r[{lo, 3'b000} +: 8] = wd[7:0];
        else                  r[{lo[1], 4'b0000} +: 16] = wd[15:0];
        return r;
    endfunction

    function automatic logic misaligned(input logic [1:0] lo, input logic [2:0] op);
        return ((op[1:0] == 2'b01) && lo[0]) || (op[1] && (lo != 2'b00));
    endfunction

    // While IDLE the access is described by the live bus; afterwards by
    // the values captured at acceptance. This lets LATENCY=0 finish from
    // IDLE directly.
    assign accept   = (state_q == IDLE) && (bus.MemRead || bus.MemWrite);
    assign cur_addr = (state_q == IDLE) ? bus.Addr      : addr_q;
    assign cur_wd   = (state_q == IDLE) ? bus.WriteData : wdata_q;
    assign cur_op   = (state_q == IDLE) ? bus.MemOp     : op_q;
    assign cur_wr   = (state_q == IDLE) ? bus.MemWrite  : wr_q;
    assign cur_idx  = cur_addr[AW+1:2];
    assign cur_word = ram[cur_idx];
    assign subword  = ~cur_op[1];
    assign new_word = subword ? store_merge(cur_word, cur_addr[1:0], cur_op, cur_wd) : cur_wd;
    assign unused_addr = ^cur_addr[31:AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
    logic fault_q;
    assign flt       = misaligned(cur_addr[1:0], cur_op);
    assign bus.Fault = fault_q;
`else
    assign flt       = 1'b0;
    assign bus.Fault = 1'b0;
`endif

    // finish marks the edge entering DONE: the write commits and load
    // data is registered on that edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end else if (cur_wr && subword) begin
                        state_d = MERGE;
                    end else begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (cur_wr && subword) begin
                        state_d = MERGE;
                    end else begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MERGE: begin
                state_d = DONE;
                finish  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.Addr;
            wdata_q <= bus.WriteData;
            op_q    <= bus.MemOp;
            wr_q    <= bus.MemWrite;
        end
    end

    // RAM write; a reset on the committing edge discards the store.
    always_ff @(posedge clk) begin
        if (finish && cur_wr && !flt && !rst) ram[cur_idx] <= new_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (finish) begin
            if (flt)          rdata_q <= '0;
            else if (!cur_wr) rdata_q <= load_extend(cur_word, cur_addr[1:0], cur_op);
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= finish && flt;
    end
`endif

    assign bus.ReadData = rdata_q;
    assign bus.Ready    = (state_q == DONE);
    assign bus.Busy     = (state_q != IDLE);
endmodule
